// File: rtl/spi_ram_arbiter_pkg.sv
// Shared definitions for the femto SPI RAM sequencer: opcodes, FSM states,
// requester IDs and the write-mask decoder.
package femto_spi_pkg;

  localparam logic [7:0] SPI_RD = 8'h03;
  localparam logic [7:0] SPI_WR = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_GAP
  } arb_state_t;

  typedef enum logic {
    PORT_IF,
    PORT_D
  } port_t;

  typedef struct packed {
    logic [1:0] s;
    logic [2:0] n;
  } start_len_t;

  // s = lowest enabled byte lane, n = number of enabled lanes.
  function automatic start_len_t mask_to_start_len(input logic [3:0] wmask);
    start_len_t r;
    r.s = '0;
    r.n = '0;
    for (int i = 3; i >= 0; i--) begin
      if (wmask[i]) r.s = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      r.n = r.n + {2'b00, wmask[i]};
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_ram_arbiter_shift_engine.sv
// Mode-0 SPI bit engine: shifts a left-aligned word out MSB first at clk/2
// and shifts miso in on the clk edge that ends each sclk-high phase.
module spi_shift_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] load_val,
  input  logic [6:0]  load_bits,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        bit_end,
  output logic        done,
  output logic [31:0] rx_next
);

  logic        busy;
  logic        phase;
  logic [62:0] out_sh;
  logic [6:0]  cnt;
  logic [31:0] rx;

  assign bit_end = busy && phase;
  assign done    = bit_end && (cnt == 7'd1);
  // Includes the bit being sampled this edge so the caller can capture the
  // final word in the same cycle the engine finishes.
  assign rx_next = {rx[30:0], miso};

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      phase  <= 1'b0;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
      out_sh <= '0;
      cnt    <= '0;
      rx     <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      phase  <= 1'b0;
      sclk   <= 1'b0;
      mosi   <= load_val[63];
      out_sh <= load_val[62:0];
      cnt    <= load_bits;
    end else if (busy) begin
      if (!phase) begin
        sclk  <= 1'b1;
        phase <= 1'b1;
      end else begin
        rx    <= rx_next;
        sclk  <= 1'b0;
        phase <= 1'b0;
        cnt   <= cnt - 7'd1;
        if (cnt == 7'd1) begin
          busy <= 1'b0;
          mosi <= 1'b0;
        end else begin
          mosi   <= out_sh[62];
          out_sh <= {out_sh[61:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one external SPI RAM,
// one READ/WRITE transaction per grant, with registered acks and read data.
module spi_ram_arbiter
  import femto_spi_pkg::*;
#(
  parameter int CS_GAP = 1,
  parameter bit RR_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [23:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_wmask,
  input  logic [23:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        spi_clk_ram,
  output logic        spi_cs_n_ram,
  output logic        spi_mosi_ram,
  input  logic        spi_miso_ram,
  output logic [2:0]  dbg_state
);

  // Handshake: a requester raises req with its inputs stable and holds them
  // until the single-cycle ack; the arbiter samples requests only in IDLE.

  arb_state_t  state, state_next;
  port_t       last_q, port_q, grant_port;
  logic        we_q;
  logic        grant_valid, zero_wr, eng_start;
  logic [5:0]  bit_idx;
  logic [15:0] gap_cnt;
  logic [63:0] load_val;
  logic [6:0]  load_bits;
  logic [31:0] wr_sh;
  start_len_t  sl;
  logic        eng_bit_end, eng_done;
  logic [31:0] eng_rx;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};
  assign dbg_state = state;

  always_comb begin
    grant_port = PORT_IF;
    if (if_req && d_req)
      grant_port = (RR_EN && last_q == PORT_D) ? PORT_IF : PORT_D;
    else if (d_req)
      grant_port = PORT_D;
    grant_valid = (state == ST_IDLE) && (if_req || d_req);
    zero_wr     = (grant_port == PORT_D) && d_we && (d_wmask == 4'b0000);
    eng_start   = grant_valid && !zero_wr;

    sl        = mask_to_start_len(d_wmask);
    wr_sh     = d_wdata >> {sl.s, 3'b000};
    load_bits = 7'd64;
    if (grant_port == PORT_IF) begin
      load_val = {SPI_RD, if_addr[23:2], 2'b00, 32'h0};
    end else if (!d_we) begin
      load_val = {SPI_RD, d_addr[23:2], 2'b00, 32'h0};
    end else begin
      // Selected lanes go out lowest byte first; unused trailing bits are never clocked.
      load_val  = {SPI_WR, d_addr[23:2], sl.s,
                   wr_sh[7:0], wr_sh[15:8], wr_sh[23:16], wr_sh[31:24]};
      load_bits = 7'd32 + {1'b0, sl.n, 3'b000};
    end

    state_next = state;
    case (state)
      ST_IDLE: if (grant_valid) state_next = zero_wr ? ST_DONE : ST_CMD;
      ST_CMD:  if (eng_bit_end && bit_idx == 6'd7) state_next = ST_ADDR;
      ST_ADDR: if (eng_bit_end && bit_idx == 6'd31) state_next = ST_DATA;
      ST_DATA: if (eng_done) state_next = ST_DONE;
      ST_DONE: state_next = ST_GAP;
      ST_GAP:  if (gap_cnt == 16'd0) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      last_q       <= PORT_IF;
      port_q       <= PORT_IF;
      we_q         <= 1'b0;
      bit_idx      <= '0;
      gap_cnt      <= '0;
      spi_cs_n_ram <= 1'b1;
      if_ack       <= 1'b0;
      d_ack        <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
    end else begin
      state  <= state_next;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;

      if (grant_valid) begin
        port_q  <= grant_port;
        last_q  <= grant_port;
        we_q    <= (grant_port == PORT_D) && d_we;
        bit_idx <= '0;
      end else if (eng_bit_end) begin
        bit_idx <= bit_idx + 6'd1;
      end

      if (eng_start) spi_cs_n_ram <= 1'b0;
      else if (eng_done) spi_cs_n_ram <= 1'b1;

      if (state == ST_IDLE && grant_valid && zero_wr) d_ack <= 1'b1;

      if (state == ST_DATA && eng_done) begin
        if (port_q == PORT_IF) begin
          if_ack   <= 1'b1;
          if_rdata <= {eng_rx[7:0], eng_rx[15:8], eng_rx[23:16], eng_rx[31:24]};
        end else begin
          d_ack <= 1'b1;
          if (!we_q)
            d_rdata <= {eng_rx[7:0], eng_rx[15:8], eng_rx[23:16], eng_rx[31:24]};
        end
      end

      if (state == ST_DONE) gap_cnt <= 16'(CS_GAP - 1);
      else if (state == ST_GAP && gap_cnt != 16'd0) gap_cnt <= gap_cnt - 16'd1;
    end
  end

  spi_shift_engine u_engine (
    .clk       (clk),
    .rst       (rst),
    .start     (eng_start),
    .load_val  (load_val),
    .load_bits (load_bits),
    .miso      (spi_miso_ram),
    .sclk      (spi_clk_ram),
    .mosi      (spi_mosi_ram),
    .bit_end   (eng_bit_end),
    .done      (eng_done),
    .rx_next   (eng_rx)
  );

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a behavioural SPI RAM and byte-level
// scoreboards for MOSI traffic and returned read words.
module tb_spi_ram_arbiter;
  import femto_spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [23:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_wmask = '0;
  logic [23:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        spi_clk_ram, spi_cs_n_ram, spi_mosi_ram;
  logic        spi_miso_ram = 1'b0;
  logic [2:0]  dbg_state;

  int compare_cnt = 0;
  int fail_cnt    = 0;
  int if_ack_cnt  = 0;
  int d_ack_cnt   = 0;
  int cs_fall_cnt = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] exp_rd_q[$];
  logic [7:0]  ram [0:4095];

  always #5 clk = ~clk;

  spi_ram_arbiter #(.CS_GAP(1), .RR_EN(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_ack       (if_ack),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_wmask      (d_wmask),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_ack        (d_ack),
    .spi_clk_ram  (spi_clk_ram),
    .spi_cs_n_ram (spi_cs_n_ram),
    .spi_mosi_ram (spi_mosi_ram),
    .spi_miso_ram (spi_miso_ram),
    .dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [23:0] a);
    logic [11:0] b;
    b = {a[11:2], 2'b00};
    return {ram[b + 12'd3], ram[b + 12'd2], ram[b + 12'd1], ram[b]};
  endfunction

  task automatic push_read(input logic [23:0] a);
    exp_q.push_back(SPI_RD);
    exp_q.push_back(a[23:16]);
    exp_q.push_back(a[15:8]);
    exp_q.push_back({a[7:2], 2'b00});
    exp_rd_q.push_back(word_at(a));
  endtask

  task automatic push_write(input logic [23:0] a, input logic [3:0] m, input logic [31:0] w);
    int s, n;
    logic [23:0] wa;
    s = 0;
    n = 0;
    for (int i = 3; i >= 0; i--) if (m[i]) s = i;
    for (int i = 0; i < 4; i++) if (m[i]) n++;
    wa = {a[23:2], 2'b00} + 24'(s);
    exp_q.push_back(SPI_WR);
    exp_q.push_back(wa[23:16]);
    exp_q.push_back(wa[15:8]);
    exp_q.push_back(wa[7:0]);
    for (int k = s; k < s + n; k++) exp_q.push_back(w[8*k +: 8]);
  endtask

  task automatic wait_ack(input bit is_d, input int start, output int cyc);
    bit got;
    cyc = start;
    got = 1'b0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      got = is_d ? (d_ack === 1'b1) : (if_ack === 1'b1);
    end
    if (!got) cyc = -1;
  endtask

  always @(posedge clk) begin
    if (if_ack === 1'b1) if_ack_cnt++;
    if (d_ack === 1'b1) d_ack_cnt++;
  end

  always @(negedge spi_cs_n_ram) cs_fall_cnt++;

  // SPI RAM model: mode 0, samples mosi on sclk rise, drives miso on sclk fall.
  logic [7:0]  mdl_sh = '0;
  logic [7:0]  mdl_op = '0;
  logic [23:0] mdl_addr = '0;
  int          mdl_bits = 0;

  always @(posedge spi_cs_n_ram) mdl_bits = 0;

  always @(posedge spi_clk_ram) begin
    logic [7:0] e;
    if (spi_cs_n_ram === 1'b0) begin
      mdl_sh = {mdl_sh[6:0], spi_mosi_ram};
      mdl_bits++;
      if (mdl_bits % 8 == 0) begin
        if (mdl_bits == 8) mdl_op = mdl_sh;
        else if (mdl_bits <= 32) mdl_addr = {mdl_addr[15:0], mdl_sh};
        else if (mdl_op == SPI_WR) ram[12'(mdl_addr + 24'((mdl_bits - 40) / 8))] = mdl_sh;
        if (mdl_bits <= 32 || mdl_op == SPI_WR) begin
          if (exp_q.size() == 0) begin
            check("mosi_unexpected", 32'(mdl_sh), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("mosi_byte", 32'(mdl_sh), 32'(e));
          end
        end
      end
    end
  end

  always @(negedge spi_clk_ram) begin
    int idx;
    logic [7:0] bv;
    if (spi_cs_n_ram === 1'b0 && mdl_op == SPI_RD && mdl_bits >= 32 && mdl_bits < 64) begin
      idx = mdl_bits - 32;
      bv = ram[12'(mdl_addr + 24'(idx / 8))];
      spi_miso_ram = bv[7 - idx % 8];
    end
  end

  initial begin
    int cyc, ifa0, da0, fall0;
    logic [7:0] snap0, snap1, snap3;
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 37 + 5);
    ram[12'h100] = 8'h11;
    ram[12'h101] = 8'h22;
    ram[12'h102] = 8'h33;
    ram[12'h103] = 8'h44;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(spi_cs_n_ram), 32'd1);
    check("rst_sclk", 32'(spi_clk_ram), 32'd0);
    check("rst_mosi", 32'(spi_mosi_ram), 32'd0);
    check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fetch read
    push_read(24'h000102);
    if_req = 1'b1;
    if_addr = 24'h000102;
    @(negedge clk);
    check("t1_cs_fall", 32'(spi_cs_n_ram), 32'd0);
    check("t1_sclk_ph0", 32'(spi_clk_ram), 32'd0);
    wait_ack(1'b0, 1, cyc);
    check("t1_ack_cycle", 32'(cyc), 32'd129);
    check("t1_if_rdata", if_rdata, exp_rd_q.pop_front());
    check("t1_if_rdata_abs", if_rdata, 32'h4433_2211);
    if_req = 1'b0;
    repeat (4) @(negedge clk);

    // Byte store
    snap0 = ram[12'h200];
    snap1 = ram[12'h201];
    snap3 = ram[12'h203];
    push_write(24'h000200, 4'b0100, 32'hAABB_CCDD);
    d_req = 1'b1;
    d_we = 1'b1;
    d_wmask = 4'b0100;
    d_addr = 24'h000200;
    d_wdata = 32'hAABB_CCDD;
    wait_ack(1'b1, 0, cyc);
    check("t2_ack_cycle", 32'(cyc), 32'd81);
    d_req = 1'b0;
    check("t2_ram200", 32'(ram[12'h200]), 32'(snap0));
    check("t2_ram201", 32'(ram[12'h201]), 32'(snap1));
    check("t2_ram202", 32'(ram[12'h202]), 32'h0000_00BB);
    check("t2_ram203", 32'(ram[12'h203]), 32'(snap3));
    check("t2_d_rdata_held", d_rdata, 32'd0);
    repeat (4) @(negedge clk);

    // Halfword store
    push_write(24'h000200, 4'b1100, 32'h1234_5678);
    d_req = 1'b1;
    d_wmask = 4'b1100;
    d_wdata = 32'h1234_5678;
    wait_ack(1'b1, 0, cyc);
    check("t3_ack_cycle", 32'(cyc), 32'd97);
    d_req = 1'b0;
    check("t3_ram202", 32'(ram[12'h202]), 32'h0000_0034);
    check("t3_ram203", 32'(ram[12'h203]), 32'h0000_0012);
    repeat (4) @(negedge clk);

    // Zero mask write
    fall0 = cs_fall_cnt;
    d_req = 1'b1;
    d_wmask = 4'b0000;
    wait_ack(1'b1, 0, cyc);
    check("t6_ack_cycle", 32'(cyc), 32'd1);
    d_req = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_no_cs", 32'(cs_fall_cnt), 32'(fall0));

    // Contention right after reset: data wins, fetch follows
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    ifa0 = if_ack_cnt;
    da0 = d_ack_cnt;
    push_read(24'h000104);
    push_read(24'h000100);
    d_we = 1'b0;
    d_addr = 24'h000104;
    d_req = 1'b1;
    if_addr = 24'h000100;
    if_req = 1'b1;
    wait_ack(1'b1, 0, cyc);
    check("t4_d_ack_cycle", 32'(cyc), 32'd129);
    check("t4_d_rdata", d_rdata, exp_rd_q.pop_front());
    check("t4_cs_high", 32'(spi_cs_n_ram), 32'd1);
    check("t4_if_not_yet", 32'(if_ack), 32'd0);
    d_req = 1'b0;
    wait_ack(1'b0, 0, cyc);
    check("t4_if_spacing", 32'(cyc), 32'd131);
    check("t4_if_rdata", if_rdata, exp_rd_q.pop_front());
    if_req = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_d_ack_count", 32'(d_ack_cnt - da0), 32'd1);
    check("t4_if_ack_count", 32'(if_ack_cnt - ifa0), 32'd1);

    // Reset in the middle of a read
    ifa0 = if_ack_cnt;
    exp_q.push_back(SPI_RD);
    exp_q.push_back(8'h00);
    if_addr = 24'h000100;
    if_req = 1'b1;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    check("t5_cs_n", 32'(spi_cs_n_ram), 32'd1);
    check("t5_sclk", 32'(spi_clk_ram), 32'd0);
    check("t5_mosi", 32'(spi_mosi_ram), 32'd0);
    check("t5_no_ack", 32'(if_ack), 32'd0);
    check("t5_if_rdata", if_rdata, 32'd0);
    check("t5_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_abort_acks", 32'(if_ack_cnt - ifa0), 32'd0);
    push_read(24'h000106);
    if_addr = 24'h000106;
    if_req = 1'b1;
    wait_ack(1'b0, 0, cyc);
    check("t5_fresh_ack_cycle", 32'(cyc), 32'd129);
    check("t5_fresh_rdata", if_rdata, exp_rd_q.pop_front());
    if_req = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_fresh_acks", 32'(if_ack_cnt - ifa0), 32'd1);
    check("mosi_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Sequencing controller for the external SPI RAM in the femto SoC. It arbitrates between the CPU instruction-fetch port and the CPU data port and converts each granted request into one SPI transaction: READ 0x03 or WRITE 0x02, then a 24-bit address, then data. It drives the `spi_*_ram` pins on the top-level `uo_out`/`ui_in` and returns read words and completion acks to the requesters.

## Interface

Parameters:
- `CS_GAP`, default 1: minimum number of cycles `spi_cs_n_ram` stays high between two transactions (≥1).
- `RR_EN`, default 1: 1 = round-robin arbitration; 0 = fixed priority, data port first.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high.
- `if_req` in 1: fetch request. Held high, with `if_addr` stable, until `if_ack`.
- `if_addr` in 24: fetch byte address. Bits [1:0] are ignored.
- `if_rdata` out 32: fetched word. Valid in the `if_ack` cycle and held until the next fetch ack.
- `if_ack` out 1: one-cycle completion pulse.
- `d_req` in 1: data request. Held, with all `d_*` inputs stable, until `d_ack`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_wmask` in 4: byte enables. Only contiguous masks are legal.
- `d_addr` in 24: data byte address. Bits [1:0] are ignored.
- `d_wdata` in 32: write word, little-endian.
- `d_rdata` out 32: read word. Valid in the `d_ack` cycle and held afterwards.
- `d_ack` out 1: one-cycle completion pulse (for both reads and writes).
- `spi_clk_ram` out 1: SPI clock, mode 0, equal to clk/2 while active.
- `spi_cs_n_ram` out 1: chip select, active low.
- `spi_mosi_ram` out 1: serial out, MSB first.
- `spi_miso_ram` in 1: serial in.

## Operation

- **FSM states:** IDLE → CMD (8 bits) → ADDR (24 bits) → DATA (8·n bits) → DONE → GAP (`CS_GAP` cycles) → IDLE.
- **Arbitration (IDLE only):**
  - With `RR_EN`=1, when both requests are pending, grant the port that was not granted last. After reset, "last granted" is fetch, so data wins the first tie.
  - The grant latches the port ID, opcode, address, write data and byte count. Inputs are not resampled after the grant.
- **Reads:**
  - Fetches and data reads send opcode 0x03 and address {addr[23:2],2'b00}.
  - They always transfer 4 bytes, regardless of `d_wmask`.
- **Writes:**
  - s = index of the lowest set bit of `d_wmask`; n = popcount(`d_wmask`).
  - Send opcode 0x02, address {addr[23:2],2'b00}+s, then bytes `d_wdata`[8s+7:8s] up to byte s+n−1, in ascending byte order.
  - `d_wmask`=0 completes immediately: ack in the cycle after the grant, no SPI activity.
- **Byte order:**
  - Each byte is shifted MSB first.
  - The first received byte goes to rdata[7:0], the fourth to rdata[31:24].
- **Bit timing:** each bit takes 2 cycles.
  - Phase 0: sclk=0 and mosi is driven.
  - Phase 1: sclk=1.
  - miso is sampled on the clk edge that ends phase 1.
- **Acks:** DONE raises `cs_n`, pulses exactly one ack (the granted port's), and updates that port's rdata register. Writes leave rdata unchanged.
- **Reset, including mid-transaction:**
  - Next cycle: `spi_cs_n_ram`=1, `spi_clk_ram`=0, `spi_mosi_ram`=0, both acks 0, both rdata=0, state IDLE, last-granted = fetch.
  - The aborted request gets no ack.
- **Request dropped early:** a request deasserted before its ack still completes on the bus and acks. Requesters must not do this; behaviour is defined only to keep the bus protocol intact.

## Timing

- **Grant:** requests are sampled in IDLE at cycle 0. `cs_n` falls at cycle 1, and the first CMD bit is in phase 0 at cycle 1.
- **Read:** 64 bits occupy cycles 1–128. DONE, with ack, is at cycle 129, and `cs_n` is high from cycle 129. The next grant is possible at cycle 129+`CS_GAP`+1.
- **Write of n bytes:** 32+8n bits. The ack comes at cycle 2·(32+8n)+1.
- **Back-to-back with `CS_GAP`=1:** a read-read pair with the second request already pending has a start-to-start spacing of 131 cycles.
- **No new grant while busy:** a new request arriving while busy waits. There is no pre-emption and no bus reuse across transactions.
- **Outputs are registered:**
  - `spi_clk_ram` is low in IDLE, DONE and GAP.
  - `spi_mosi_ram` is 0 when `cs_n`=1.

## Structure

- **Package `femto_spi_pkg`:**
  - Opcodes `SPI_RD`=8'h03 and `SPI_WR`=8'h02.
  - FSM state enum.
  - Port-ID enum (`PORT_IF`, `PORT_D`).
  - Function `mask_to_start_len(wmask)`, returning s and n.
- **Sub-module `spi_shift_engine`:**
  - Loads a 64-bit out-shift value and a bit count.
  - Generates sclk/mosi and shifts in miso.
  - Signals `done`.
- **Top:** `spi_ram_arbiter` holds the arbiter, request latch, FSM sequencing and ack/rdata registers.

## Test plan

1. **Fetch read:** a RAM model holds 0x11,0x22,0x33,0x44 at 0x000100. Issue `if_req`, `if_addr`=0x000102 → MOSI shows 0x03, 0x000100. `if_ack` at cycle 129 with `if_rdata`=0x44332211.
2. **Byte store:** `d_we`=1, `d_wmask`=4'b0100, `d_addr`=0x000200, `d_wdata`=0xAABBCCDD → MOSI 0x02, 0x000202, 0xBB. Ack at cycle 81, and only RAM[0x202] changes.
3. **Halfword store:** `d_wmask`=4'b1100, `d_wdata`=0x12345678 → address 0x000202, bytes 0x34 then 0x12. Ack at cycle 97.
4. **Contention:** `if_req` and `d_req` both asserted at cycle 0 after reset → data is served first, fetch second. `cs_n` is high at least `CS_GAP` cycles in between. Each port gets exactly one ack.
5. **Reset mid-transaction:** `rst` at cycle 40 of a read → the next cycle shows `cs_n`=1, `sclk`=0 and no ack. A fresh request afterwards completes normally.
6. **Zero mask:** `d_we`=1, `d_wmask`=0 → `d_ack` one cycle after the grant, and `cs_n` never falls.
